// File: rtl/lfsr_bit_packer.sv
// Packs the serial LFSR output bit MSB-first into words and buffers them in a
// first-word-fall-through FIFO with a saturating overflow drop counter.
module lfsr_bit_packer #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  input  logic                       flush,
  output logic [WORD_W-1:0]          word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       overflow
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned BCW = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [BCW-1:0] LastBit = BCW'(WORD_W - 1);
  localparam logic [PW:0]    FullLvl = (PW + 1)'(DEPTH);

  logic [WORD_W-1:0] r_sr;
  logic [BCW-1:0]    r_bit_cnt;
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW:0]       r_fill;
  logic [CNT_W-1:0]  r_drop;
  logic              r_ovf;

  logic              w_shift;
  logic              w_complete;
  logic [WORD_W-1:0] w_word;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  // Flush beats a simultaneous valid bit, even on a would-be completing edge.
  assign w_shift    = bit_valid & ~flush;
  assign w_complete = w_shift & (r_bit_cnt == LastBit);
  assign w_word     = {r_sr[WORD_W-2:0], bit_in};

  assign w_empty = (r_fill == '0);
  assign w_full  = (r_fill == FullLvl);
  assign w_pop   = ~w_empty & word_ready;
  // When full, a same-edge pop frees the slot the push lands in.
  assign w_push  = w_complete & (~w_full | w_pop);
  assign w_drop  = w_complete & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else if (flush) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else if (bit_valid) begin
      r_sr      <= w_word;
      r_bit_cnt <= w_complete ? '0 : r_bit_cnt + BCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_fill <= r_fill + (PW + 1)'(1);
      else if (w_pop && !w_push) r_fill <= r_fill - (PW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop != '1) r_drop <= r_drop + CNT_W'(1);
    end
  end

  // Memory is not reset, so gate the head word with the non-empty flag.
  assign word_out   = w_empty ? '0 : r_mem[r_rptr];
  assign word_valid = ~w_empty;
  assign fill_level = r_fill;
  assign drop_cnt   = r_drop;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_lfsr_bit_packer.sv
// Directed bench for lfsr_bit_packer: a default instance plus a CNT_W=2 instance
// sharing the same stimulus, to observe drop-counter saturation.
module tb_lfsr_bit_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       flush;
  logic       word_ready;

  logic [7:0] a_word_out;
  logic       a_word_valid;
  logic [2:0] a_fill;
  logic [7:0] a_drop;
  logic       a_ovf;

  logic [7:0] b_word_out;
  logic       b_word_valid;
  logic [2:0] b_fill;
  logic [1:0] b_drop;
  logic       b_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lfsr_bit_packer #(.WORD_W(8), .DEPTH(4), .CNT_W(8)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .flush      (flush),
    .word_out   (a_word_out),
    .word_valid (a_word_valid),
    .word_ready (word_ready),
    .fill_level (a_fill),
    .drop_cnt   (a_drop),
    .overflow   (a_ovf)
  );

  lfsr_bit_packer #(.WORD_W(8), .DEPTH(4), .CNT_W(2)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .flush      (flush),
    .word_out   (b_word_out),
    .word_valid (b_word_valid),
    .word_ready (word_ready),
    .fill_level (b_fill),
    .drop_cnt   (b_drop),
    .overflow   (b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    flush      = 1'b0;
    word_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic drain_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'd0, a_word_valid}, 32'd1);
    check(tag, {24'd0, a_word_out}, {24'd0, exp});
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_valid", {31'd0, a_word_valid}, 32'd0);
    check("rst_word",  {24'd0, a_word_out}, 32'd0);
    check("rst_fill",  {29'd0, a_fill}, 32'd0);
    check("rst_drop",  {24'd0, a_drop}, 32'd0);
    check("rst_ovf",   {31'd0, a_ovf}, 32'd0);

    // First word: 1,0,1,1,0,0,1,0 -> 0xB2
    for (int i = 7; i >= 1; i--) send_bit(logic'((8'hB2 >> i) & 8'h01));
    check("t1_early_valid", {31'd0, a_word_valid}, 32'd0);
    send_bit(1'b0);
    check("t1_valid", {31'd0, a_word_valid}, 32'd1);
    check("t1_word",  {24'd0, a_word_out}, 32'h0000_00B2);
    check("t1_fill",  {29'd0, a_fill}, 32'd1);

    // Overflow by one word, then drain
    do_reset();
    for (int k = 1; k <= 5; k++) send_byte(8'(k));
    check("t2_fill", {29'd0, a_fill}, 32'd4);
    check("t2_head", {24'd0, a_word_out}, 32'h01);
    check("t2_drop", {24'd0, a_drop}, 32'd1);
    check("t2_ovf",  {31'd0, a_ovf}, 32'd1);
    drain_check("t2_pop1", 8'h01);
    drain_check("t2_pop2", 8'h02);
    drain_check("t2_pop3", 8'h03);
    drain_check("t2_pop4", 8'h04);
    check("t2_empty",     {31'd0, a_word_valid}, 32'd0);
    check("t2_ovf_stick", {31'd0, a_ovf}, 32'd1);

    // Full FIFO, pop on the completing edge of 0x3C
    do_reset();
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h40);
    check("t3_full", {29'd0, a_fill}, 32'd4);
    for (int i = 7; i >= 1; i--) send_bit(logic'((8'h3C >> i) & 8'h01));
    word_ready = 1'b1;
    send_bit(1'b0);
    word_ready = 1'b0;
    check("t3_fill", {29'd0, a_fill}, 32'd4);
    check("t3_drop", {24'd0, a_drop}, 32'd0);
    check("t3_ovf",  {31'd0, a_ovf}, 32'd0);
    drain_check("t3_pop1", 8'h20);
    drain_check("t3_pop2", 8'h30);
    drain_check("t3_pop3", 8'h40);
    drain_check("t3_pop4", 8'h3C);

    // Flush with a valid bit discards the partial word and that bit
    do_reset();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    flush = 1'b1;
    send_bit(1'b1);
    flush = 1'b0;
    check("t4_post_flush", {29'd0, a_fill}, 32'd0);
    send_byte(8'hA5);
    check("t4_fill", {29'd0, a_fill}, 32'd1);
    check("t4_word", {24'd0, a_word_out}, 32'h0000_00A5);

    // Gaps every other cycle; gap-cycle bit_in carries garbage
    do_reset();
    for (int j = 0; j < 16; j++) begin
      logic [15:0] stream;
      logic        b;
      stream = 16'h5AC3;
      b      = stream[15-j];
      send_bit(b);
      bit_in = ~b;
      tick();
    end
    check("t5_fill", {29'd0, a_fill}, 32'd2);
    drain_check("t5_pop1", 8'h5A);
    drain_check("t5_pop2", 8'hC3);

    // Nine words, no pop: five drops; CNT_W=2 instance saturates at 3
    do_reset();
    for (int k = 1; k <= 9; k++) send_byte(8'(k * 8'h11));
    check("t6_a_drop", {24'd0, a_drop}, 32'd5);
    check("t6_b_drop", {30'd0, b_drop}, 32'd3);
    check("t6_b_ovf",  {31'd0, b_ovf}, 32'd1);
    check("t6_b_fill", {29'd0, b_fill}, 32'd4);
    check("t6_b_head", {24'd0, b_word_out}, 32'h11);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_ar_valid", {31'd0, b_word_valid}, 32'd0);
    check("t6_ar_word",  {24'd0, b_word_out}, 32'd0);
    check("t6_ar_fill",  {29'd0, b_fill}, 32'd0);
    check("t6_ar_drop",  {30'd0, b_drop}, 32'd0);
    check("t6_ar_ovf",   {31'd0, b_ovf}, 32'd0);
    check("t6_ar_a_drop", {24'd0, a_drop}, 32'd0);
    check("t6_ar_a_fill", {29'd0, a_fill}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
